// File: rtl/apb_timer_pkg.sv
// Shared constants and types for the APB timer slave.
// Register offsets, ID value, CTRL bit positions, front-end states.
package apb_timer_pkg;

    localparam logic [11:0] CTRL_OFS   = 12'h000;
    localparam logic [11:0] LOAD_OFS   = 12'h004;
    localparam logic [11:0] COUNT_OFS  = 12'h008;
    localparam logic [11:0] STATUS_OFS = 12'h00C;
    localparam logic [11:0] ID_OFS     = 12'h010;

    localparam logic [31:0] TIMER_ID = 32'hA9B0_0001;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// Down-counter timer: CTRL/LOAD/COUNT/STATUS flops.
// Driven by decoded write strobes from the APB front-end.
module apb_timer_core
    import apb_timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ctrl_we,
    input  logic                  load_we,
    input  logic                  status_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [2:0]            ctrl,
    output logic [DATA_WIDTH-1:0] load,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  expired,
    output logic                  irq
);

    logic expire;

    assign expire = ctrl[CTRL_EN] & (count == '0);
    assign irq    = expired & ctrl[CTRL_IE];

    // CTRL: a software write beats the one-shot self-disable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= wdata[2:0];
        end else if (expire && !ctrl[CTRL_AR]) begin
            ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // LOAD: plain software register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load <= '0;
        end else if (load_we) begin
            load <= wdata;
        end
    end

    // COUNT: LOAD writes win over ticks; stops at 0 unless reloading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_we) begin
            count <= wdata;
        end else if (ctrl[CTRL_EN]) begin
            if (count != '0) begin
                count <= count - DATA_WIDTH'(1);
            end else if (ctrl[CTRL_AR]) begin
                count <= load;
            end
        end
    end

    // STATUS.expired: set wins over write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (status_we && wdata[0]) begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// APB3 slave front-end with wait states and error decode.
// Responses are zero unless a transfer completes this cycle.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  irq_o
);

    apb_state_e state, state_nx;
    logic [3:0] wcnt, wcnt_nx;
    logic       done;

    logic [11:0]           ofs;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  hit;
    logic                  ro;
    logic                  err;
    logic                  wr_ok;

    logic                  ctrl_we;
    logic                  load_we;
    logic                  status_we;
    logic [2:0]            ctrl;
    logic [DATA_WIDTH-1:0] load;
    logic [DATA_WIDTH-1:0] count;
    logic                  expired;
    logic                  irq;

    logic unused_addr;

    assign ofs         = paddr_i[11:0];
    assign unused_addr = ^paddr_i[ADDR_WIDTH-1:12];

    // Front-end state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Next state: setup loads wcnt, access counts it down to completion
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (psel_i && !penable_i) begin
                    state_nx = S_ACCESS;
                    wcnt_nx  = 4'(WAIT_CYCLES);
                end
            end
            S_ACCESS: begin
                if (!psel_i) begin
                    state_nx = S_IDLE;
                end else if (penable_i) begin
                    if (wcnt != '0) begin
                        wcnt_nx = wcnt - 4'd1;
                    end else begin
                        done     = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address decode: read mux, hit and read-only flags
    always_comb begin
        rdata = '0;
        hit   = 1'b0;
        ro    = 1'b0;
        unique case (1'b1)
            (ofs == CTRL_OFS): begin
                hit   = 1'b1;
                rdata = DATA_WIDTH'(ctrl);
            end
            (ofs == LOAD_OFS): begin
                hit   = 1'b1;
                rdata = load;
            end
            (ofs == COUNT_OFS): begin
                hit   = 1'b1;
                ro    = 1'b1;
                rdata = count;
            end
            (ofs == STATUS_OFS): begin
                hit   = 1'b1;
                rdata = DATA_WIDTH'(expired);
            end
            (ofs == ID_OFS): begin
                hit   = 1'b1;
                ro    = 1'b1;
                rdata = DATA_WIDTH'(TIMER_ID);
            end
            default: ;
        endcase
    end

    assign err   = ~hit | (pwrite_i & ro);
    assign wr_ok = done & pwrite_i & ~err;

    assign ctrl_we   = wr_ok & (ofs == CTRL_OFS);
    assign load_we   = wr_ok & (ofs == LOAD_OFS);
    assign status_we = wr_ok & (ofs == STATUS_OFS);

    assign pready_o  = done;
    assign pslverr_o = done & err;
    assign prdata_o  = (done && !err && !pwrite_i) ? rdata : '0;
    assign irq_o     = irq;

    apb_timer_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl_we  (ctrl_we),
        .load_we  (load_we),
        .status_we(status_we),
        .wdata    (pwdata_i),
        .ctrl     (ctrl),
        .load     (load),
        .count    (count),
        .expired  (expired),
        .irq      (irq)
    );

endmodule
